misao_mem_responder: RTL
========================

MISAO_MEM_RESPONDER -- requirements
Module: misao_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  256  bytes of internal RAM, power of two, 2..32768
  BOOT_LOAD  1  1 = leave reset in LOAD state, 0 = leave reset in RUN state
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on its rising edge
  rst  in  1  asynchronous, active-high reset
  mem_enable_read  in  1  CPU read strobe
  mem_enable_write  in  1  CPU write strobe
  mem_addr  in  15  CPU byte address
  mem_rw  in  1  CPU direction flag; informational only, strobes decide
  mem_data_out  in  8  CPU write data
  mem_data_in  out  8  read data returned to CPU
  load_valid  in  1  boot byte offered
  load_data  in  8  boot byte
  load_last  in  1  marks the final boot byte
  load_ready  out  1  responder accepts a boot byte
  reload  in  1  pulse; re-enter LOAD from RUN
  cpu_rst  out  1  hold CPU in reset
  bus_err  out  1  sticky out-of-range access flag
  loaded_bytes  out  log2(DEPTH)+1  count of boot bytes accepted in current load

Function
REQ-003 The block SHALL implement the FSM states LOAD, HOLD and RUN.
REQ-004 In LOAD: cpu_rst=1, load_ready=1; each cycle with load_valid=1 SHALL write load_data to RAM[load_addr], increment load_addr and increment loaded_bytes.
REQ-005 LOAD->HOLD SHALL occur on an accepted byte with load_last=1, or on an accepted byte at load_addr=DEPTH-1 (auto-terminate, no wrap).
REQ-006 HOLD SHALL last exactly one cycle with cpu_rst=1 and load_ready=0, then go to RUN; cpu_rst falls 2 edges after the last accepted byte.
REQ-007 In RUN: cpu_rst=0, load_ready=0; load_valid is ignored.
REQ-008 In RUN, reload=1 at an edge SHALL go to LOAD and clear load_addr and loaded_bytes; a CPU write in that same cycle is still committed.
REQ-009 A CPU read SHALL be combinational, zero wait state: mem_data_in = RAM[mem_addr] when mem_enable_read=1 and mem_addr<DEPTH, else 8'h00.
REQ-010 A CPU write SHALL commit mem_data_out to RAM[mem_addr] at the edge, only in RUN, only when mem_enable_write=1 and mem_addr<DEPTH.
REQ-011 When a read and a write target the same address in the same cycle, the read SHALL return the pre-write data.
REQ-012 An out-of-range access (either strobe with mem_addr>=DEPTH) in RUN SHALL leave RAM unchanged, read 8'h00 and set bus_err; bus_err is cleared only by rst.
REQ-013 CPU strobes in LOAD or HOLD SHALL have no effect on RAM or bus_err; reads still return data per REQ-009.
REQ-014 loaded_bytes SHALL saturate at DEPTH and hold its value through HOLD and RUN until the next LOAD entry.

Reset
REQ-015 rst SHALL asynchronously force: state = LOAD if BOOT_LOAD=1, else RUN; load_addr=0, loaded_bytes=0, bus_err=0.
REQ-016 Outputs during reset SHALL be: cpu_rst=1, load_ready=0, mem_data_in per REQ-009.
REQ-017 RAM contents SHALL NOT be cleared by rst; reset mid-load restarts the load at address 0.

Verification
REQ-018 Boot load: bytes 18,4E,84 with load_last on 84 -> RAM[0..2]=18,4E,84, loaded_bytes=3, cpu_rst low 2 cycles after acceptance.
REQ-019 RUN write/read: write 05 @0x0080, then read @0x0080 -> mem_data_in=05; simultaneous write 03 and read @0x0081 (old 00) -> read 00, next read 03.
REQ-020 Out of range: read @0x0100 with DEPTH=256 -> mem_data_in=00 and bus_err=1; write AA @0x0100 -> RAM unchanged, bus_err stays 1.
REQ-021 Overflow: 256 bytes without load_last -> auto HOLD after byte 255, loaded_bytes=256, RAM[0] not overwritten.
REQ-022 rst asserted after 2 of 4 bytes, then 4 bytes reloaded -> RAM[0..3] = new bytes, loaded_bytes=4.
REQ-023 reload pulse with write 77 @0x0010 in the same cycle -> RAM[0x10]=77, cpu_rst=1 next cycle, loaded_bytes=0.

Source files
------------

// File: rtl/misao_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : misao_mem_responder
// Description : Byte-wide CPU memory responder with a boot-load front end.
//               A boot stream fills the RAM (LOAD), a one-cycle HOLD follows,
//               then the CPU is released (RUN) and gets zero-wait-state reads
//               and edge-committed writes. Out-of-range CPU accesses in RUN
//               raise a sticky bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
module misao_mem_responder #(
  parameter int DEPTH     = 256,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_enable_read,
  input  logic                     mem_enable_write,
  input  logic [14:0]              mem_addr,
  input  logic                     mem_rw,
  input  logic [7:0]               mem_data_out,
  output logic [7:0]               mem_data_in,
  input  logic                     load_valid,
  input  logic [7:0]               load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  input  logic                     reload,
  output logic                     cpu_rst,
  output logic                     bus_err,
  output logic [$clog2(DEPTH):0]   loaded_bytes
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_RESET = BOOT_LOAD ? ST_LOAD : ST_RUN;

  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] C_ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] C_LAST     = AW'(DEPTH - 1);
  localparam logic [15:0]   C_LIMIT    = 16'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic [AW:0]   loaded_bytes_q, loaded_bytes_d;
  logic          bus_err_q, bus_err_d;

  logic [7:0]    mem_q [DEPTH];

  logic          w_in_range;
  logic [AW-1:0] w_cpu_idx;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [7:0]    w_ram_wdata;
  logic          w_unused;

  // The direction flag carries no meaning here; the strobes decide.
  assign w_unused   = mem_rw;

  assign w_in_range = ({1'b0, mem_addr} < C_LIMIT);
  assign w_cpu_idx  = mem_addr[AW-1:0];

  // Zero-wait-state read; a same-cycle write lands at the edge, so the
  // read naturally returns the pre-write byte.
  assign mem_data_in = (mem_enable_read && w_in_range) ? mem_q[w_cpu_idx] : 8'h00;

  assign cpu_rst      = rst | (state_q != ST_RUN);
  assign load_ready   = ~rst & (state_q == ST_LOAD);
  assign bus_err      = bus_err_q;
  assign loaded_bytes = loaded_bytes_q;

  // Next-state, load bookkeeping and single RAM write-port selection.
  always_comb begin
    state_d        = state_q;
    load_addr_d    = load_addr_q;
    loaded_bytes_d = loaded_bytes_q;
    bus_err_d      = bus_err_q;
    w_ram_we       = 1'b0;
    w_ram_addr     = load_addr_q;
    w_ram_wdata    = load_data;
    case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          w_ram_we    = 1'b1;
          load_addr_d = load_addr_q + C_ADDR_ONE;
          if (loaded_bytes_q != C_DEPTH) begin
            loaded_bytes_d = loaded_bytes_q + C_CNT_ONE;
          end
          // Last top-of-RAM byte ends the load instead of wrapping onto 0.
          if (load_last || (load_addr_q == C_LAST)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if ((mem_enable_read || mem_enable_write) && !w_in_range) begin
          bus_err_d = 1'b1;
        end
        if (mem_enable_write && w_in_range) begin
          w_ram_we    = 1'b1;
          w_ram_addr  = w_cpu_idx;
          w_ram_wdata = mem_data_out;
        end
        // A write in the reload cycle is still committed above.
        if (reload) begin
          state_d        = ST_LOAD;
          load_addr_d    = '0;
          loaded_bytes_d = '0;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Control state; reset restarts any load at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RESET;
      load_addr_q    <= '0;
      loaded_bytes_q <= '0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_addr_q    <= load_addr_d;
      loaded_bytes_q <= loaded_bytes_d;
      bus_err_q      <= bus_err_d;
    end
  end

  // RAM array; contents survive reset, writes are blocked while it is held.
  always_ff @(posedge clk) begin
    if (w_ram_we && !rst) begin
      mem_q[w_ram_addr] <= w_ram_wdata;
    end
  end

endmodule
`default_nettype wire
